// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the wait-state data memory.
// Access size encoding, FSM states and a size-to-offset-mask helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_e;

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_lsb_mask(input mem_size_e sz);
        logic [3:0] nb;
        nb = 4'd1 << sz;
        return 3'(nb - 4'd1);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane placement for stores and lane extraction
// with sign/zero extension for loads (purely combinational).
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0]   rword,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [LANE_W-1:0]   lane,
    input  mem_size_e           size,
    input  logic                uns,
    output logic [DATA_W-1:0]   rdata,
    output logic [DATA_W-1:0]   wshift,
    output logic [DATA_W/8-1:0] wbe
);

    localparam int BYTES = DATA_W / 8;

    logic [LANE_W+2:0] sh_amt;
    logic [DATA_W-1:0] rsh;
    logic [DATA_W-1:0] lmask;
    logic [7:0]        be8;
    logic [6:0]        nbits;
    logic              sbit;

    always_comb begin
        sh_amt = {lane, 3'b000};
        rsh    = rword >> sh_amt;
        wshift = wdata << sh_amt;
        be8    = 8'h01;
        nbits  = 7'd8;
        sbit   = rsh[7];
        unique case (size)
            SZ_B: begin
                be8   = 8'h01;
                nbits = 7'd8;
                sbit  = rsh[7];
            end
            SZ_H: begin
                be8   = 8'h03;
                nbits = 7'd16;
                sbit  = rsh[15];
            end
            SZ_W: begin
                be8   = 8'h0F;
                nbits = 7'd32;
                sbit  = rsh[31];
            end
            SZ_D: begin
                be8   = 8'hFF;
                nbits = 7'd64;
                sbit  = rsh[DATA_W-1];
            end
        endcase
        wbe   = BYTES'(be8 << lane);
        // A shift by the full width yields zero, so a full-word mask is all ones
        lmask = ~({DATA_W{1'b1}} << nbits);
        rdata = (rsh & lmask) | (~lmask & {DATA_W{sbit & ~uns}});
    end

endmodule

// File: rtl/dmem_wait.sv
// dmem_wait: data memory with a fixed LATENCY-cycle wait state per request.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning down.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = ADDR_W - LANE_W;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam bit LAT0   = (LATENCY == 0);
    localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    dmem_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        enter_resp;
    logic        accept;

    logic              we_q, we_d;
    mem_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              cur_we;
    mem_size_e         cur_size;
    logic              cur_uns;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    logic [2:0]        lsb_m;
    logic [ADDR_W-1:0] addr_al;
    logic              bad_align;
    logic              bad_size;
    logic              err;
    logic [IDX_W-1:0]  widx;
    logic [LANE_W-1:0] lane;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] wshift;
    logic [BYTES-1:0]  wbe;
    logic [DATA_W-1:0] bit_m;
    logic              mem_wr;

    assign accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (LAT0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is held low through reset so nothing is accepted before release
    always_comb begin
        req_ready = reset_b & (state_q != ST_WAIT);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = req_we;
            size_d  = mem_size_e'(req_size);
            uns_d   = req_unsigned;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // With zero latency the request commits on its own accepting edge
    always_comb begin
        cur_we    = LAT0 ? req_we : we_q;
        cur_size  = LAT0 ? mem_size_e'(req_size) : size_q;
        cur_uns   = LAT0 ? req_unsigned : uns_q;
        cur_addr  = LAT0 ? req_addr : addr_q;
        cur_wdata = LAT0 ? req_wdata : wdata_q;
    end

    always_comb begin
        lsb_m    = size_lsb_mask(cur_size);
        bad_size = (cur_size == SZ_D) && (DATA_W == 32);
`ifdef DMEM_MISALIGN_TRAP_EN
        addr_al   = cur_addr;
        bad_align = |(cur_addr[2:0] & lsb_m);
`else
        addr_al   = cur_addr & ~ADDR_W'(lsb_m);
        bad_align = 1'b0;
`endif
        err  = bad_size | bad_align;
        widx = addr_al[ADDR_W-1:LANE_W];
        lane = addr_al[LANE_W-1:0];
    end

    assign rword = mem[widx];

    dmem_lane_align #(
        .DATA_W(DATA_W),
        .LANE_W(LANE_W)
    ) u_align (
        .rword (rword),
        .wdata (cur_wdata),
        .lane  (lane),
        .size  (cur_size),
        .uns   (cur_uns),
        .rdata (ld_data),
        .wshift(wshift),
        .wbe   (wbe)
    );

    always_comb begin
        bit_m = '0;
        for (int i = 0; i < BYTES; i++) begin
            bit_m[8*i +: 8] = {8{wbe[i]}};
        end
        mem_wr = enter_resp & cur_we & ~err;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[widx] <= (rword & ~bit_m) | (wshift & bit_m);
        end
    end

    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (enter_resp) begin
            rsp_err_d   = err;
            rsp_rdata_d = (err | cur_we) ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
